// File: rtl/axis_ifft_8point_idft_pkg.sv
// Shared types, constants and helpers for the 8-point inverse DFT pipeline.
package ifft8_pkg;

  localparam int C_AXIS_TDATA_WIDTH = 512;
  localparam int C_AXIS_TOUT_WIDTH  = 64;
  localparam int C_INT_WIDTH        = 36;
  localparam logic signed [15:0] C_TWIDDLE = 16'sd23170;

  localparam logic signed [C_INT_WIDTH-1:0] C_SAT_MAX = C_INT_WIDTH'(127);
  localparam logic signed [C_INT_WIDTH-1:0] C_SAT_MIN = C_INT_WIDTH'(-128);

  typedef struct packed {
    logic signed [C_INT_WIDTH-1:0] re;
    logic signed [C_INT_WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [7:0] cvec8_t;

  typedef struct packed {
    logic       sat;
    logic [7:0] val;
  } sat8_t;

  function automatic cplx_t cadd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  function automatic cplx_t csub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

  // Multiply by +j: (re, im) -> (-im, re).
  function automatic cplx_t mulj(input cplx_t a);
    cplx_t r;
    r.re = -a.im;
    r.im = a.re;
    return r;
  endfunction

  // Bin k lives at [64k+63:64k] as {re, im}, each 32-bit signed.
  function automatic cvec8_t unpack8(input logic [C_AXIS_TDATA_WIDTH-1:0] d);
    cvec8_t c;
    for (int k = 0; k < 8; k++) begin
      c[k].re = C_INT_WIDTH'($signed(d[64*k+32 +: 32]));
      c[k].im = C_INT_WIDTH'($signed(d[64*k +: 32]));
    end
    return c;
  endfunction

  function automatic logic [C_AXIS_TOUT_WIDTH-1:0] pack8(input logic [7:0][7:0] s);
    return s;
  endfunction

  function automatic sat8_t sat8(input logic signed [C_INT_WIDTH-1:0] v);
    sat8_t r;
    if (v > C_SAT_MAX)      r = '{sat: 1'b1, val: 8'h7f};
    else if (v < C_SAT_MIN) r = '{sat: 1'b1, val: 8'h80};
    else                    r = '{sat: 1'b0, val: v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/axis_ifft_8point_idft_if.sv
// AXI-Stream channel bundle; W sets the tdata width.
interface axis_ifft_8point_idft_if #(parameter int W = 64);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_ifft_8point_idft_cmul.sv
// Combinational multiply by W8^-K (K = 0..3); products floor-shifted back to Q0.
module ifft8_cmul_w8
  import ifft8_pkg::*;
#(
  parameter int K = 0
) (
  input  cplx_t i_a,
  output cplx_t o_z
);

  localparam int PW = C_INT_WIDTH + 17;
  localparam logic signed [PW-1:0] C_TW = PW'(C_TWIDDLE);

  if (K == 0) begin : g_k0
    assign o_z = i_a;
  end else if (K == 2) begin : g_k2
    assign o_z = mulj(i_a);
  end else begin : g_k13
    logic signed [PW-1:0] w_dif, w_sum;
    assign w_dif = (PW'(i_a.re) - PW'(i_a.im)) * C_TW;
    assign w_sum = (PW'(i_a.re) + PW'(i_a.im)) * C_TW;
    if (K == 1) begin : g_k1
      assign o_z.re = C_INT_WIDTH'(w_dif >>> 15);
      assign o_z.im = C_INT_WIDTH'(w_sum >>> 15);
    end else begin : g_k3
      assign o_z.re = C_INT_WIDTH'((-w_sum) >>> 15);
      assign o_z.im = C_INT_WIDTH'(w_dif >>> 15);
    end
  end

endmodule

// File: rtl/axis_ifft_8point_idft.sv
// 8-point radix-2 DIT inverse DFT, 4-stage AXI-Stream pipeline, 1/8 scaled Q7 output.
module axis_ifft_8point_idft
  import ifft8_pkg::*;
(
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  axis_ifft_8point_idft_if.slave  s_axis,
  axis_ifft_8point_idft_if.master m_axis
);

  logic                         w_adv;
  logic [4:1]                   r_vld_pipe, r_last_pipe;
  cvec8_t                       r_p1, r_p2, r_p3;
  cvec8_t                       w_s1, w_s2, w_x;
  cplx_t [3:0]                  w_t;
  logic [7:0][7:0]              w_smp;
  logic [7:0]                   w_satf;
  logic                         w_unused_im;
  logic [C_AXIS_TOUT_WIDTH-1:0] r_tdata;
  logic                         r_tuser;

  // Whole pipeline moves as one unit whenever the output slot can be refilled.
  assign w_adv         = ~r_vld_pipe[4] | m_axis.tready;
  assign s_axis.tready = w_adv;

  assign m_axis.tvalid = r_vld_pipe[4];
  assign m_axis.tlast  = r_last_pipe[4];
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tuser  = r_tuser;

  // Stage 1: bit-reversed pairs (0,4) (2,6) (1,5) (3,7).
  always_comb begin
    w_s1    = '0;
    w_s1[0] = cadd(r_p1[0], r_p1[4]);
    w_s1[1] = csub(r_p1[0], r_p1[4]);
    w_s1[2] = cadd(r_p1[2], r_p1[6]);
    w_s1[3] = csub(r_p1[2], r_p1[6]);
    w_s1[4] = cadd(r_p1[1], r_p1[5]);
    w_s1[5] = csub(r_p1[1], r_p1[5]);
    w_s1[6] = cadd(r_p1[3], r_p1[7]);
    w_s1[7] = csub(r_p1[3], r_p1[7]);
  end

  // Stage 2: two 4-point inverse halves; [3:0] even bins, [7:4] odd bins.
  always_comb begin
    w_s2 = '0;
    for (int h = 0; h < 8; h += 4) begin
      w_s2[h]   = cadd(r_p2[h],   r_p2[h+2]);
      w_s2[h+2] = csub(r_p2[h],   r_p2[h+2]);
      w_s2[h+1] = cadd(r_p2[h+1], mulj(r_p2[h+3]));
      w_s2[h+3] = csub(r_p2[h+1], mulj(r_p2[h+3]));
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_tw
    ifft8_cmul_w8 #(.K(k)) u_cmul (.i_a(r_p3[4+k]), .o_z(w_t[k]));
  end

  // Stage 3 plus round-half-up /8 and clamp; only real parts reach the output.
  always_comb begin
    w_x         = '0;
    w_smp       = '0;
    w_satf      = '0;
    w_unused_im = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_x[k]   = cadd(r_p3[k], w_t[k]);
      w_x[k+4] = csub(r_p3[k], w_t[k]);
    end
    for (int n = 0; n < 8; n++) begin
      {w_satf[n], w_smp[n]} = sat8((w_x[n].re + C_INT_WIDTH'(4)) >>> 3);
      w_unused_im ^= ^w_x[n].im;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_tdata     <= '0;
      r_tuser     <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe  <= {r_vld_pipe[3:1], s_axis.tvalid};
      r_last_pipe <= {r_last_pipe[3:1], s_axis.tvalid & s_axis.tlast};
      r_p1        <= unpack8(s_axis.tdata);
      r_p2        <= w_s1;
      r_p3        <= w_s2;
      r_tdata     <= pack8(w_smp);
      r_tuser     <= r_vld_pipe[3] & (|w_satf);
    end
  end

endmodule

// File: tb/tb_axis_ifft_8point_idft.sv
// Directed scoreboard bench for axis_ifft_8point_idft against a real-valued IDFT model.
module tb_axis_ifft_8point_idft;

  localparam real PI = 3.14159265358979323846;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_ifft_8point_idft_if #(.W(512)) s_if ();
  axis_ifft_8point_idft_if #(.W(64))  m_if ();

  axis_ifft_8point_idft dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (s_if),
    .m_axis         (m_if)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        user;
    int          tol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   g_re[8];
  int   g_im[8];
  int   ramp[8] = '{-96, -64, -32, 0, 32, 64, 96, 127};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [63:0] got, input logic [63:0] exp,
                         input int tol);
    logic ok;
    ok = !$isunknown(got);
    for (int n = 0; n < 8; n++) begin
      int dg, de;
      dg = $signed(got[8*n +: 8]);
      de = $signed(exp[8*n +: 8]);
      if (dg - de > tol || de - dg > tol) ok = 1'b0;
    end
    n_checks++;
    assert (ok === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 8; k++) begin
      g_re[k] = 0;
      g_im[k] = 0;
    end
  endtask

  task automatic rnd_bins();
    for (int k = 0; k < 8; k++) begin
      g_re[k] = int'($urandom_range(120)) - 60;
      g_im[k] = int'($urandom_range(120)) - 60;
    end
  endtask

  // x_n = round_half_up(1/8 * Re(sum X_k e^{+j2pi kn/8})), clamped to int8.
  function automatic exp_t model(input logic last, input int tol);
    exp_t e;
    e.data = '0;
    e.last = last;
    e.user = 1'b0;
    e.tol  = tol;
    for (int n = 0; n < 8; n++) begin
      real acc, th;
      int  v;
      acc = 0.0;
      for (int k = 0; k < 8; k++) begin
        th  = 2.0 * PI * real'(k * n) / 8.0;
        acc = acc + real'(g_re[k]) * $cos(th) - real'(g_im[k]) * $sin(th);
      end
      v = $rtoi($floor(acc / 8.0 + 0.5));
      if (v > 127) begin
        v = 127; e.user = 1'b1;
      end else if (v < -128) begin
        v = -128; e.user = 1'b1;
      end
      e.data[8*n +: 8] = 8'(v);
    end
    return e;
  endfunction

  task automatic send(input exp_t e);
    logic [511:0] d;
    logic         acc;
    for (int k = 0; k < 8; k++) begin
      d[64*k+32 +: 32] = g_re[k];
      d[64*k +: 32]    = g_im[k];
    end
    s_if.tdata  = d;
    s_if.tlast  = e.last;
    s_if.tvalid = 1'b1;
    sb.push_back(e);
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
    end
    chk("accept", 64'(acc), 64'd1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_tol("tdata", m_if.tdata, e.data, e.tol);
        chk("tlast", 64'(m_if.tlast), 64'(e.last));
        chk("tuser", 64'(m_if.tuser), 64'(e.user));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: no summary after 400000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    logic [63:0] held_d;
    logic [1:0]  held_lu;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    clr();

    // Reset state
    #12;
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata",  m_if.tdata,       64'd0);
    chk("rst_tlast",  64'(m_if.tlast),  64'd0);
    chk("rst_tuser",  64'(m_if.tuser),  64'd0);
    chk("rst_sready", 64'(s_if.tready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // DC bin with latency: visible after the 4th edge counting the accept
    clr(); g_re[0] = 512;
    send(model(1'b0, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat_early", 64'(m_if.tvalid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", 64'(m_if.tvalid), 64'd1);
    chk("dc_data",   m_if.tdata, 64'h4040404040404040);
    drain();

    // Flat spectrum
    clr();
    for (int k = 0; k < 8; k++) g_re[k] = 64;
    send(model(1'b0, 0));
    drain();

    // Cosine: even samples exact, odd within 1 LSB
    clr(); g_re[1] = 256; g_re[7] = 256;
    send(model(1'b0, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("cos_even", m_if.tdata & 64'h00FF00FF00FF00FF, 64'h000000C000000040);
    drain();

    // Saturation both directions
    clr(); g_re[0] = 1600;
    send(model(1'b0, 0));
    drain();
    clr(); g_re[0] = -1600;
    send(model(1'b0, 0));
    drain();

    // Backpressure: 4 beats in, stall 3 cycles on first output, then the rest
    for (int b = 0; b < 4; b++) begin
      rnd_bins(); g_re[0] = 8 * b;
      send(model(1'b0, 1));
    end
    m_if.tready = 1'b0;
    chk("bp_valid", 64'(m_if.tvalid), 64'd1);
    held_d  = m_if.tdata;
    held_lu = {m_if.tlast, m_if.tuser};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", m_if.tdata, held_d);
      chk("bp_hold_lu",   64'({m_if.tlast, m_if.tuser}), 64'(held_lu));
      chk("bp_sready",    64'(s_if.tready), 64'd0);
    end
    m_if.tready = 1'b1;
    for (int b = 4; b < 6; b++) begin
      rnd_bins(); g_re[0] = 8 * b;
      send(model(b == 5, 1));
    end
    drain();

    // Reset with 3 beats in flight
    for (int b = 0; b < 3; b++) begin
      rnd_bins();
      send(model(1'b0, 1));
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_mid_tdata",  m_if.tdata,       64'd0);
    chk("rst_mid_sready", 64'(s_if.tready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      rnd_bins();
      send(model(b == 1, 1));
    end
    drain();

    // Round trip: forward DFT of a Q7 ramp, expect the ramp back within 1 LSB
    for (int k = 0; k < 8; k++) begin
      real ar, ai, th;
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        th = 2.0 * PI * real'(k * n) / 8.0;
        ar = ar + real'(ramp[n]) * $cos(th);
        ai = ai - real'(ramp[n]) * $sin(th);
      end
      g_re[k] = $rtoi($floor(ar + 0.5));
      g_im[k] = $rtoi($floor(ai + 0.5));
    end
    e.data = '0;
    for (int n = 0; n < 8; n++) e.data[8*n +: 8] = 8'(ramp[n]);
    e.last = 1'b1;
    e.user = 1'b0;
    e.tol  = 1;
    send(e);
    drain();

    repeat (6) @(posedge clk);
    #1;
    chk("idle_tvalid", 64'(m_if.tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
